order_tx_framer: RTL and testbench

//  Consumes the 7-word order record that the reverse parser presents on its output registers with a one-cycle valid.

---
 rtl/order_tx_framer_if.sv | 11 +
 rtl/order_tx_framer.sv | 225 ++++++++++++++++++++++
 tb/tb_order_tx_framer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/order_tx_framer_if.sv
// Egress byte stream between the order frame serializer and the host/MAC side.
// The framer drives data/valid/last; the consumer drives ready.
interface order_tx_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/order_tx_framer.sv
// Order record framer: buffers whole 7-word order records in a small frame
// FIFO and serializes each as header, 28 big-endian payload bytes and an
// XOR checksum byte on a valid/ready byte stream.
//
// state | meaning
// IDLE  | FIFO empty, stream quiet
// HDR   | presenting the header byte of the head record
// PAY   | presenting payload byte r_idx of the head record
// CHK   | presenting the checksum byte, last marker high
module order_tx_framer #(
  parameter int          REG_WIDTH  = 32,
  parameter int          NUM_REGS   = 7,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  HDR_BYTE   = 8'h4F,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [REG_WIDTH-1:0]  i_reg_1,
  input  logic [REG_WIDTH-1:0]  i_reg_2,
  input  logic [REG_WIDTH-1:0]  i_reg_3,
  input  logic [REG_WIDTH-1:0]  i_reg_4,
  input  logic [REG_WIDTH-1:0]  i_reg_5,
  input  logic [REG_WIDTH-1:0]  i_reg_6,
  input  logic [REG_WIDTH-1:0]  i_reg_7,
  input  logic                  i_valid,
  order_tx_framer_if.master     tx,
  output logic                  o_fifo_full,
  output logic [CNT_WIDTH-1:0]  o_drop_count,
  output logic [CNT_WIDTH-1:0]  o_frames_sent
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int REC_W     = NUM_REGS * REG_WIDTH;
  localparam int PAY_BYTES = REC_W / 8;
  localparam int IDX_W     = $clog2(PAY_BYTES);
  localparam int SEL_W     = $clog2(REC_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_BYTES - 1);
  localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;

  // Payload byte 0 is the most significant byte of reg_1 (top of the record).
  function automatic logic [7:0] f_pay_byte(input logic [REC_W-1:0] rec,
                                            input logic [IDX_W-1:0] idx);
    logic [SEL_W-1:0] lo;
    lo = SEL_W'(LAST_IDX - idx) << 3;
    return rec[lo +: 8];
  endfunction

  logic [REC_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_full;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_csum;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_tx_last;
  logic [CNT_WIDTH-1:0] r_drop;
  logic [CNT_WIDTH-1:0] r_sent;

  logic [REC_W-1:0]     w_rec;
  logic [REC_W-1:0]     w_head;
  logic                 w_hs;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [AW:0]          w_count_nxt;

  state_t               w_state_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [7:0]           w_csum_nxt;
  logic [7:0]           w_data_nxt;
  logic                 w_valid_nxt;
  logic                 w_last_nxt;

  assign w_rec  = {i_reg_1, i_reg_2, i_reg_3, i_reg_4, i_reg_5, i_reg_6, i_reg_7};
  assign w_head = r_mem[r_rd_ptr];
  assign w_hs   = r_tx_valid && tx.tx_ready;
  assign w_pop  = (r_state == S_CHK) && w_hs;
  // A full FIFO still accepts when the head record leaves at the same edge.
  assign w_push = i_valid && (!r_full || w_pop);
  assign w_drop = i_valid && !w_push;

  // Occupancy after this edge.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Record storage: only the tail slot is ever written.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
    end
  end

  // Next state plus next registered stream outputs; everything holds without a handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_csum_nxt  = r_csum;
    w_data_nxt  = r_tx_data;
    w_valid_nxt = r_tx_valid;
    w_last_nxt  = r_tx_last;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = S_HDR;
          w_csum_nxt  = 8'h00;
          w_data_nxt  = HDR_BYTE;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
        end else begin
          w_data_nxt  = 8'h00;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          w_state_nxt = S_PAY;
          w_idx_nxt   = '0;
          w_csum_nxt  = r_csum ^ r_tx_data;
          w_data_nxt  = f_pay_byte(w_head, '0);
        end
      end
      S_PAY: begin
        if (w_hs) begin
          w_csum_nxt = r_csum ^ r_tx_data;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_CHK;
            w_data_nxt  = r_csum ^ r_tx_data;
            w_last_nxt  = 1'b1;
          end else begin
            w_idx_nxt  = r_idx + 1'b1;
            w_data_nxt = f_pay_byte(w_head, r_idx + 1'b1);
          end
        end
      end
      S_CHK: begin
        if (w_hs) begin
          w_last_nxt = 1'b0;
          if (w_count_nxt != '0) begin
            w_state_nxt = S_HDR;
            w_csum_nxt  = 8'h00;
            w_data_nxt  = HDR_BYTE;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_data_nxt  = 8'h00;
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_data_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and registered stream outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_csum     <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_csum     <= w_csum_nxt;
      r_tx_data  <= w_data_nxt;
      r_tx_valid <= w_valid_nxt;
      r_tx_last  <= w_last_nxt;
    end
  end

  // Saturating drop and sent counters.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_drop <= '0;
      r_sent <= '0;
    end else begin
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      if (w_pop  && (r_sent != '1)) r_sent <= r_sent + 1'b1;
    end
  end

  assign tx.tx_data    = r_tx_data;
  assign tx.tx_valid   = r_tx_valid;
  assign tx.tx_last    = r_tx_last;
  assign o_fifo_full   = r_full;
  assign o_drop_count  = r_drop;
  assign o_frames_sent = r_sent;

endmodule

// File: tb/tb_order_tx_framer.sv
module tb_order_tx_framer;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } byte_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reg_v [7];
  logic        valid;
  logic        valid2;
  logic        full, full2;
  logic [15:0] drop, sent;
  logic [2:0]  drop2, sent2;

  order_tx_framer_if txi ();
  order_tx_framer_if tx2 ();

  order_tx_framer dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_reg_1(reg_v[0]), .i_reg_2(reg_v[1]), .i_reg_3(reg_v[2]), .i_reg_4(reg_v[3]),
    .i_reg_5(reg_v[4]), .i_reg_6(reg_v[5]), .i_reg_7(reg_v[6]),
    .i_valid(valid), .tx(txi),
    .o_fifo_full(full), .o_drop_count(drop), .o_frames_sent(sent)
  );

  order_tx_framer #(.CNT_WIDTH(3)) dut_small (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_reg_1(reg_v[0]), .i_reg_2(reg_v[1]), .i_reg_3(reg_v[2]), .i_reg_4(reg_v[3]),
    .i_reg_5(reg_v[4]), .i_reg_6(reg_v[5]), .i_reg_7(reg_v[6]),
    .i_valid(valid2), .tx(tx2),
    .o_fifo_full(full2), .o_drop_count(drop2), .o_frames_sent(sent2)
  );

  always #5 clk = ~clk;

  int    n_pass  = 0;
  int    n_total = 0;
  byte_t exp_q[$];
  int    occ = 0;
  int    byte_in_frame = 0;
  int    exp_drop = 0;
  int    exp_sent = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] rec_byte(input int k);
    return 8'(reg_v[k / 4] >> (8 * (3 - (k % 4))));
  endfunction

  // Reference model: a frame is 0x4F, the 28 big-endian payload bytes, then the XOR of all of them.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      occ = 0; byte_in_frame = 0; exp_drop = 0; exp_sent = 0;
    end else begin
      bit pop_now;
      pop_now = 1'b0;
      if (txi.tx_valid && txi.tx_ready) begin
        if (byte_in_frame == 29) begin
          pop_now = 1'b1;
          byte_in_frame = 0;
        end else begin
          byte_in_frame++;
        end
      end
      if (pop_now) begin
        occ--;
        exp_sent++;
      end
      if (valid) begin
        if (occ < 4) begin
          logic [7:0] cs;
          byte_t e;
          cs = 8'h4F;
          e.d = 8'h4F; e.l = 1'b0; exp_q.push_back(e);
          for (int k = 0; k < 28; k++) begin
            e.d = rec_byte(k); e.l = 1'b0;
            cs = cs ^ e.d;
            exp_q.push_back(e);
          end
          e.d = cs; e.l = 1'b1; exp_q.push_back(e);
          occ++;
        end else begin
          exp_drop++;
        end
      end
    end
  end

  // Monitor: compares every accepted byte and holds stalled bytes to account.
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", txi.tx_valid, 1'b1);
        check("stall_data_held", txi.tx_data, prev_data);
        check("stall_last_held", txi.tx_last, prev_last);
      end
      if (txi.tx_valid && txi.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", txi.tx_data, $time);
        end else begin
          byte_t e;
          e = exp_q.pop_front();
          check("tx_data", txi.tx_data, e.d);
          check("tx_last", txi.tx_last, e.l);
        end
      end
      stall_prev = txi.tx_valid && !txi.tx_ready;
      prev_data  = txi.tx_data;
      prev_last  = txi.tx_last;
    end
  end

  task automatic push_one();
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic rand_rec();
    for (int i = 0; i < 7; i++) reg_v[i] = $urandom;
  endtask

  task automatic drain(input bit rnd, input int budget, output int cyc);
    cyc = 0;
    while ((exp_q.size() != 0 || txi.tx_valid) && cyc < budget) begin
      txi.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_in_budget", 32'(cyc < budget), 1);
    txi.tx_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int found;
    logic [15:0] drop_before;
    logic [15:0] sent_before;

    rst_n = 1'b0; valid = 1'b0; valid2 = 1'b0;
    txi.tx_ready = 1'b0; tx2.tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) reg_v[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", txi.tx_valid, 0);
    check("rst_tx_last", txi.tx_last, 0);
    check("rst_tx_data", txi.tx_data, 0);
    check("rst_fifo_full", full, 0);
    check("rst_drop", drop, 0);
    check("rst_sent", sent, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: registers 1..7, ready high
    txi.tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) reg_v[i] = 32'(i + 1);
    push_one();
    @(posedge clk); #1;
    check("t1_latency_valid", txi.tx_valid, 1);
    check("t1_header", txi.tx_data, 8'h4F);
    drain(1'b0, 200, cyc);
    check("t1_frames_sent", sent, 1);

    // 2: same record, random back-pressure
    txi.tx_ready = 1'b0;
    push_one();
    drain(1'b1, 1000, cyc);
    check("t2_frames_sent", sent, 2);

    // 3: five consecutive pushes with ready low
    txi.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_rec();
      valid = 1'b1;
      @(posedge clk); #1;
      if (i == 2) check("t3_not_full_3", full, 0);
      if (i == 3) check("t3_full_4", full, 1);
    end
    valid = 1'b0;
    check("t3_drop", drop, 1);
    drain(1'b0, 500, cyc);
    check("t3_no_gap_cycles", cyc, 120);
    check("t3_sent", sent, 16'(exp_sent));

    // 4: push at the same edge as the checksum handshake while full
    txi.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_rec();
      push_one();
    end
    check("t4_full_before", full, 1);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      txi.tx_ready = 1'b1;
      if (txi.tx_valid && txi.tx_last) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("t4_reached_chk", found, 1);
    drop_before = drop;
    sent_before = sent;
    rand_rec();
    push_one();
    check("t4_full_after", full, 1);
    check("t4_drop_unchanged", drop, drop_before);
    check("t4_sent_incr", sent, sent_before + 16'd1);
    drain(1'b0, 1000, cyc);
    check("t4_sent", sent, 16'(exp_sent));

    // 5: reset in the middle of a payload
    txi.tx_ready = 1'b1;
    rand_rec();
    push_one();
    repeat (12) @(posedge clk);
    #1;
    check("t5_idx10_byte", txi.tx_data, rec_byte(10));
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", txi.tx_valid, 0);
    check("t5_rst_last", txi.tx_last, 0);
    check("t5_rst_data", txi.tx_data, 0);
    check("t5_rst_sent", sent, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rand_rec();
    push_one();
    drain(1'b0, 200, cyc);
    check("t5_sent_after_reset", sent, 1);

    // randomized traffic with drops and back-pressure
    for (int i = 0; i < 400; i++) begin
      txi.tx_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0) begin
        rand_rec();
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    drain(1'b0, 2000, cyc);
    check("rand_drop", drop, 16'(exp_drop));
    check("rand_sent", sent, 16'(exp_sent));
    check("rand_not_full", full, 0);

    // 6: 3-bit drop counter saturation (4 accepted, then 10 drops)
    for (int i = 0; i < 14; i++) begin
      int d;
      rand_rec();
      valid2 = 1'b1;
      @(posedge clk); #1;
      d = (i + 1 > 4) ? (i + 1 - 4) : 0;
      if (d > 7) d = 7;
      check("t6_drop_sat", drop2, d);
    end
    valid2 = 1'b0;
    check("t6_full", full2, 1);
    check("t6_sent", sent2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
